// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmds_pkg
// Description : Shared TMDS definitions: control-token constants, the
//               token-match function and the word-aligner state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    localparam logic [9:0] c_CTRL_TOKEN_0 = 10'b1101010100;
    localparam logic [9:0] c_CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [9:0] c_CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [9:0] c_CTRL_TOKEN_3 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_t;

    function automatic logic is_ctrl_token(input logic [9:0] word);
        return (word == c_CTRL_TOKEN_0) || (word == c_CTRL_TOKEN_1) ||
               (word == c_CTRL_TOKEN_2) || (word == c_CTRL_TOKEN_3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_bit_window.sv
`default_nettype none
// ============================================================================
// Module      : tmds_bit_window
// Description : 20-bit sliding window over two consecutive deserialized
//               words with a 10:1 bit-offset word selector.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_bit_window (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_data,
    input  logic [3:0] i_offset,
    output logic [9:0] o_word
);

    logic [9:0]  r_prev_word;
    logic [19:0] w_window;
    logic [9:0]  w_tap [10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_word <= '0;
        end else begin
            r_prev_word <= i_data;
        end
    end

    // Older word sits in the low half, so bit 0 stays the earliest serial bit.
    assign w_window = {i_data, r_prev_word};

    for (genvar k = 0; k < 10; k++) begin : g_tap
        assign w_tap[k] = w_window[k+9:k];
    end

    assign o_word = (i_offset < 4'd10) ? w_tap[i_offset] : w_tap[0];

endmodule
`default_nettype wire

// File: rtl/tmds_word_align.sv
`default_nettype none
// ============================================================================
// Module      : tmds_word_align
// Description : TMDS receive word aligner. Hunts for control tokens across
//               the ten bit offsets and emits boundary-aligned words with a
//               lock flag. Optional slip counter: TMDS_ALIGN_SLIP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_word_align
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS  = 16,
    parameter int SEARCH_WAIT  = 32,
    parameter int LOSS_TIMEOUT = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] data_in,
    output logic [9:0] data_out,
    output logic       token,
    output logic       locked,
    output logic [3:0] offset
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    ,
    output logic [7:0] slip_count
`endif
);

    localparam int c_WAIT_W = (SEARCH_WAIT > 1) ? $clog2(SEARCH_WAIT) : 1;
    localparam int c_LOSS_W = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;
    localparam int c_RUN_W  = $clog2(LOCK_TOKENS + 1);

    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(SEARCH_WAIT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [c_LOSS_W-1:0] c_LOSS_LAST = c_LOSS_W'(LOSS_TIMEOUT - 1);
    localparam logic [c_LOSS_W-1:0] c_LOSS_ONE  = c_LOSS_W'(1);
    localparam logic [c_RUN_W-1:0]  c_RUN_LAST  = c_RUN_W'(LOCK_TOKENS - 1);
    localparam logic [c_RUN_W-1:0]  c_RUN_ONE   = c_RUN_W'(1);

    align_state_t        r_state,  w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait,   w_wait_nxt;
    logic [c_LOSS_W-1:0] r_loss,   w_loss_nxt;
    logic [c_RUN_W-1:0]  r_run,    w_run_nxt;
    logic [1:0]          r_blind,  w_blind_nxt;
    logic [3:0]          r_offset, w_offset_nxt;
    logic [9:0]          w_cand;
    logic                w_is_tok;
    logic [9:0]          r_data_out;
    logic                r_token;
    logic                r_locked;

    tmds_bit_window u_window (
        .clk      (clk),
        .rst      (rst),
        .i_data   (data_in),
        .i_offset (r_offset),
        .o_word   (w_cand)
    );

    assign w_is_tok = is_ctrl_token(w_cand);

    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_loss_nxt   = r_loss;
        w_run_nxt    = r_run;
        w_offset_nxt = r_offset;
        w_blind_nxt  = (r_blind != 2'd0) ? r_blind - 2'd1 : 2'd0;
        case (r_state)
            ST_SEARCH: begin
                w_loss_nxt = '0;
                // A token on the terminal-count cycle wins over the slip.
                if (w_is_tok && (r_blind == 2'd0)) begin
                    w_state_nxt = ST_VERIFY;
                    w_run_nxt   = c_RUN_ONE;
                    w_wait_nxt  = '0;
                end else if (r_wait == c_WAIT_LAST) begin
                    w_wait_nxt   = '0;
                    w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    w_blind_nxt  = 2'd2;
                end else begin
                    w_wait_nxt = r_wait + c_WAIT_ONE;
                end
            end
            ST_VERIFY: begin
                w_wait_nxt = '0;
                if (w_is_tok) begin
                    w_run_nxt = r_run + c_RUN_ONE;
                    if (r_run == c_RUN_LAST) begin
                        w_state_nxt = ST_LOCKED;
                        w_loss_nxt  = '0;
                    end
                end else begin
                    w_state_nxt = ST_SEARCH;
                    w_run_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                w_wait_nxt = '0;
                if (w_is_tok) begin
                    w_loss_nxt = '0;
                end else if (r_loss == c_LOSS_LAST) begin
                    w_state_nxt = ST_SEARCH;
                    w_loss_nxt  = '0;
                    w_run_nxt   = '0;
                end else begin
                    w_loss_nxt = r_loss + c_LOSS_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_SEARCH;
            r_wait   <= '0;
            r_loss   <= '0;
            r_run    <= '0;
            r_blind  <= '0;
            r_offset <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wait   <= w_wait_nxt;
            r_loss   <= w_loss_nxt;
            r_run    <= w_run_nxt;
            r_blind  <= w_blind_nxt;
            r_offset <= w_offset_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_token    <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_data_out <= w_cand;
            r_token    <= w_is_tok;
            r_locked   <= (r_state == ST_LOCKED);
        end
    end

    assign data_out = r_data_out;
    assign token    = r_token;
    assign locked   = r_locked;
    assign offset   = r_offset;

`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    logic [7:0] r_slip_count;
    logic       w_slip;
    logic       w_lock_entry;

    assign w_slip       = (r_state == ST_SEARCH) && (w_offset_nxt != r_offset);
    assign w_lock_entry = (r_state == ST_VERIFY) && (w_state_nxt == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slip_count <= '0;
        end else if (w_lock_entry) begin
            r_slip_count <= '0;
        end else if (w_slip && (r_slip_count != 8'hFF)) begin
            r_slip_count <= r_slip_count + 8'd1;
        end
    end

    assign slip_count = r_slip_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tmds_word_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_tmds_word_align
// Description : Self-checking bench for tmds_word_align against a serial-bit
//               reference model; slip counter checked with TMDS_ALIGN_SLIP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_word_align;

    localparam int LT   = 16;
    localparam int SW   = 32;
    localparam int LOSS = 256;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] PIX  = 10'b0111110000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       token;
    logic       locked;
    logic [3:0] offset;
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
    logic [7:0] slip_count;
`endif

    always #5 clk = ~clk;

    tmds_word_align #(
        .LOCK_TOKENS  (LT),
        .SEARCH_WAIT  (SW),
        .LOSS_TIMEOUT (LOSS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .token    (token),
        .locked   (locked),
        .offset   (offset)
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
        ,
        .slip_count (slip_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Reference model: operates on the serial bit history, not a window register
    int         m_mode;   // 0 hunting, 1 confirming, 2 holding
    int         m_quiet, m_streak, m_silence, m_blind, m_off, m_slips;
    logic [9:0] m_prev;
    logic [9:0] nxt_data, exp_data;
    logic       nxt_tok, exp_tok, nxt_locked, exp_locked;
    int         nxt_off, exp_off, nxt_slip, exp_slip;

    logic       sq[$];
    logic [9:0] toks [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    function automatic bit tok_ref(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_quiet = 0; m_streak = 0; m_silence = 0;
        m_blind = 0; m_off = 0; m_slips = 0; m_prev = '0;
        exp_data = '0; exp_tok = 1'b0; exp_locked = 1'b0; exp_off = 0; exp_slip = 0;
    endtask

    task automatic model_step(input logic [9:0] cur);
        logic [9:0] cand;
        bit         t;
        bit         seen;
        for (int i = 0; i < 10; i++) begin
            int idx = m_off + i;
            cand[i] = (idx < 10) ? m_prev[idx] : cur[idx-10];
        end
        t          = tok_ref(cand);
        nxt_data   = cand;
        nxt_tok    = t;
        nxt_locked = (m_mode == 2);
        case (m_mode)
            0: begin
                seen = t && (m_blind == 0);
                if (m_blind > 0) m_blind--;
                if (seen) begin
                    m_mode = 1; m_streak = 1; m_quiet = 0;
                end else if (m_quiet == SW - 1) begin
                    m_quiet = 0; m_off = (m_off + 1) % 10; m_blind = 2;
                    if (m_slips < 255) m_slips++;
                end else begin
                    m_quiet++;
                end
            end
            1: begin
                if (t) begin
                    m_streak++;
                    if (m_streak == LT) begin
                        m_mode = 2; m_silence = 0; m_slips = 0;
                    end
                end else begin
                    m_mode = 0; m_quiet = 0; m_streak = 0;
                end
            end
            default: begin
                if (t) m_silence = 0;
                else if (m_silence == LOSS - 1) begin
                    m_mode = 0; m_silence = 0; m_quiet = 0;
                end else m_silence++;
            end
        endcase
        nxt_off  = m_off;
        nxt_slip = m_slips;
        m_prev   = cur;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("data_out", int'(data_out), int'(exp_data));
            check("token",    int'(token),    int'(exp_tok));
            check("locked",   int'(locked),   int'(exp_locked));
            check("offset",   int'(offset),   exp_off);
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
            check("slip_count", int'(slip_count), exp_slip);
`endif
        end
    end

    task automatic step(input logic [9:0] w);
        data_in = w;
        model_step(w);
        @(posedge clk);
        exp_data = nxt_data; exp_tok = nxt_tok; exp_locked = nxt_locked;
        exp_off = nxt_off; exp_slip = nxt_slip;
        chk_en = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic push_word(input logic [9:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) sq.push_back(w[i]);
    endtask

    task automatic pop_word(output logic [9:0] w);
        for (int i = 0; i < 10; i++) w[i] = sq.pop_front();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        data_in = '0;
        sq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once
    task automatic mid_reset();
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_data_out", int'(data_out), 0);
        check("async_rst_token",    int'(token),    0);
        check("async_rst_locked",   int'(locked),   0);
        check("async_rst_offset",   int'(offset),   0);
        sq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] w;
        rst = 1'b1;
        data_in = '0;
        model_reset();
        do_reset();
        rst = 1'b1;
        #1;
        check("reset_data_out", int'(data_out), 0);
        check("reset_token",    int'(token),    0);
        check("reset_locked",   int'(locked),   0);
        check("reset_offset",   int'(offset),   0);

        // Aligned stream
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            step(TOK0);
            if (c == 1)  check("aligned_token_clk1", int'(token), 0);
            if (c == 2)  check("aligned_token_clk2", int'(token), 1);
            if (c == 2)  check("aligned_data_clk2", int'(data_out), int'(TOK0));
            if (c == 17) check("aligned_locked_clk17", int'(locked), 0);
            if (c == 18) check("aligned_locked_clk18", int'(locked), 1);
            if (c == 18) check("aligned_offset", int'(offset), 0);
        end

        // Skew of 3 bits, then loss of lock with offset retained
        do_reset();
        push_word(10'd0, 3);
        for (int i = 0; i < 130; i++) push_word(TOK0, 10);
        for (int i = 0; i < 400; i++) push_word(PIX, 10);
        for (int c = 1; c <= 400; c++) begin
            pop_word(w);
            step(w);
            if (c == 31)  check("skew3_offset_c31", int'(offset), 0);
            if (c == 32)  check("skew3_offset_c32", int'(offset), 1);
            if (c == 64)  check("skew3_offset_c64", int'(offset), 2);
            if (c == 96)  check("skew3_offset_c96", int'(offset), 3);
            if (c == 114) check("skew3_locked_c114", int'(locked), 0);
            if (c == 115) check("skew3_locked_c115", int'(locked), 1);
            if (c == 115) check("skew3_data", int'(data_out), int'(TOK0));
            if (c == 387) check("loss_locked_c387", int'(locked), 1);
            if (c == 388) check("loss_locked_c388", int'(locked), 0);
            if (c == 388) check("loss_offset_kept", int'(offset), 3);
        end
        mid_reset();

        // Broken verify
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            step((c == 10) ? PIX : TOK0);
            if (c == 11) check("broken_offset", int'(offset), 0);
            if (c == 27) check("broken_locked_c27", int'(locked), 0);
            if (c == 28) check("broken_locked_c28", int'(locked), 1);
        end

        // Token on the loss terminal-count cycle keeps lock
        do_reset();
        for (int c = 1; c <= 291; c++) begin
            step((c <= 20 || c == 276) ? TOK0 : PIX);
            if (c == 278) check("late_token_locked_c278", int'(locked), 1);
            if (c == 279) check("late_token_locked_c279", int'(locked), 1);
        end
        mid_reset();

        // Skew of 7 bits
        do_reset();
        push_word(10'd0, 7);
        for (int i = 0; i < 260; i++) push_word(TOK0, 10);
        for (int c = 1; c <= 260; c++) begin
            pop_word(w);
            step(w);
            if (c == 230) check("skew7_offset", int'(offset), 7);
            if (c == 245) check("skew7_locked", int'(locked), 1);
`ifdef TMDS_ALIGN_SLIP_COUNT_EN
            if (c == 230) check("skew7_slips_before_lock", int'(slip_count), 7);
            if (c == 245) check("skew7_slips_after_lock", int'(slip_count), 0);
`endif
        end

        // Randomized episodes
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            push_word(10'($urandom), int'($urandom_range(0, 9)));
            for (int i = 0; i < 350; i++)
                push_word(($urandom_range(0, 39) == 0) ? 10'($urandom) : toks[$urandom_range(0, 3)], 10);
            for (int i = 0; i < 300; i++) push_word(10'($urandom), 10);
            for (int i = 0; i < 60; i++) push_word(toks[$urandom_range(0, 3)], 10);
            while (sq.size() >= 10) begin
                pop_word(w);
                step(w);
            end
        end

`ifdef TMDS_ALIGN_SLIP_COUNT_EN
        // Tokenless stream: slip counter saturates
        do_reset();
        for (int c = 1; c <= 8200; c++) begin
            step(10'd0);
            if (c == 8128) check("slip_254", int'(slip_count), 254);
            if (c == 8160) check("slip_255", int'(slip_count), 255);
            if (c == 8192) check("slip_saturated", int'(slip_count), 255);
        end
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmds_word_align.md
Name: tmds_word_align

Overview:
- Receive-side counterpart to the TMDS 10:1 output serializer.
- Takes raw 10-bit words from a 1:10 input deserializer in the parallel clock domain. The word boundary of these raw words is arbitrary.
- Finds the correct bit offset by hunting for TMDS control tokens, then outputs boundary-aligned 10-bit words with a lock indication.
- Sits between the deserializer and the TMDS decoder, one instance per channel.

Parameters:
- LOCK_TOKENS, 16, consecutive control tokens required at one offset to declare lock.
- SEARCH_WAIT, 32, cycles spent at one offset in SEARCH without any token before slipping to the next offset.
- LOSS_TIMEOUT, 1048576, cycles in LOCKED without any token before lock is dropped.

Ports:
- clk  input  1  parallel (word) clock.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  10  raw deserialized word; bit 0 is the earliest-received serial bit.
- data_out  output  10  aligned word.
- token  output  1  data_out is one of the four control tokens.
- locked  output  1  alignment locked.
- offset  output  4  current bit offset, 0..9.

Behaviour:
- Window:
  - prev_word register holds the previous data_in.
  - Window = {data_in, prev_word}, 20 bits.
  - Candidate word at offset k = window[k+9:k].
- Outputs and latency:
  - data_out and token are registered: 1 cycle after data_in is presented.
  - The prev_word pipeline adds 1 word of history. First valid data_out after reset is on the 2nd clock.
- Control tokens, as [9:0] values: 10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011. Token detection is made on the candidate word.
- Reset: asynchronous. All outputs are 0 (data_out=0, token=0, locked=0, offset=0). prev_word=0, counters=0, state=SEARCH. Assertion mid-operation abandons lock immediately.
- States:
  - SEARCH:
    - Candidate is a token: go to VERIFY with run counter=1.
    - Otherwise the wait counter increments. When it reaches SEARCH_WAIT-1:
      - offset increments, wrapping 9->0;
      - the wait counter clears;
      - the next 2 cycles are ignored for token detection while the window refills;
      - state stays SEARCH.
  - VERIFY:
    - Token: run counter increments. When the run counter reaches LOCK_TOKENS, go to LOCKED.
    - Non-token: return to SEARCH. Offset is unchanged; wait and run counters clear.
  - LOCKED:
    - locked=1, registered; it rises the cycle after entry.
    - Any token clears the loss counter.
    - When the loss counter reaches LOSS_TIMEOUT-1, go to SEARCH. locked falls the following cycle; offset is retained.
- Offset is frozen outside SEARCH.
- Counter widths come from $clog2 of their parameter. Counters never wrap: wait and loss counters are bounded by their terminal compare, and the run counter stops at LOCK_TOKENS.
- A token arriving on the same cycle as the SEARCH_WAIT terminal count takes priority: go to VERIFY, no slip.
- A token arriving on the same cycle as the LOSS_TIMEOUT terminal count takes priority: stay LOCKED.

Optional Feature:
- Macro: TMDS_ALIGN_SLIP_COUNT_EN.
- When defined:
  - adds output slip_count[7:0], reset 0;
  - slip_count increments on every offset slip and saturates at 255;
  - slip_count clears on entry to LOCKED from VERIFY.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants, shared with the TMDS encoder and decoder;
  - the token-match function;
  - the alignment state encoding (SEARCH, VERIFY, LOCKED).
- One natural sub-module, tmds_bit_window. It is the 20-bit window register plus the 10:1 offset multiplexer, and is reusable by a later fabric deserializer.

Test Plan:
- Reset:
  - Stimulus: assert rst asynchronously mid-stream.
  - Required response: data_out=0, token=0, locked=0, offset=0 without waiting for a clock edge.
- Aligned stream:
  - Stimulus: repeated 10'b1101010100 at offset 0.
  - Required response: token=1 from clock 2; locked=1 after 16 consecutive tokens plus 1 cycle; offset=0.
- Skewed stream:
  - Stimulus: token stream delayed by 3 serial bits.
  - Required response: offset steps 0->1->2->3, each step after 32 token-free cycles; lock at offset=3; data_out=10'b1101010100.
- Broken verify:
  - Stimulus: 9 tokens, then pixel word 10'b0111110000, then tokens again.
  - Required response: return to SEARCH; offset unchanged; locked only after a fresh 16 tokens.
- Loss of lock:
  - Stimulus: build with LOSS_TIMEOUT=256. After lock, feed pixel words only.
  - Required response: locked falls after 256 cycles with offset retained. A token at cycle 255 keeps lock.
- Slip counter (TMDS_ALIGN_SLIP_COUNT_EN):
  - Stimulus: skew of 7 bits.
  - Required response: slip_count=7 before lock, then 0 after lock.
  - Stimulus: a tokenless stream.
  - Required response: slip_count saturates at 255.
